// File: rtl/hashtable_index_lookup_upd_if.sv
`default_nettype none
// ============================================================================
// Module : hashtable_index_lookup_upd_if
// Brief  : Lookup, result and table-update bundle for the segment-table lookup.
// Rev    : 1.0
// ============================================================================
interface hashtable_index_lookup_upd_if #(
    parameter int INDEX_BIT_LEN   = 11,
    parameter int PACKET_BIT_LEN  = 104,
    parameter int TABLE_ADDR_BITS = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [PACKET_BIT_LEN-1:0]  tupleData;
    logic                       out_valid;
    logic                       out_hit;
    logic                       smallorbig_segment;
    logic [INDEX_BIT_LEN-1:0]   seg_index;
    logic                       upd_valid;
    logic                       upd_ready;
    logic [TABLE_ADDR_BITS-1:0] upd_addr;
    logic                       upd_clear;
    logic                       upd_flag;
    logic [INDEX_BIT_LEN-1:0]   upd_index;
    logic                       init_done;

    modport master (
        output in_valid, tupleData, upd_valid, upd_addr, upd_clear, upd_flag, upd_index,
        input  in_ready, out_valid, out_hit, smallorbig_segment, seg_index, upd_ready, init_done
    );

    modport slave (
        input  in_valid, tupleData, upd_valid, upd_addr, upd_clear, upd_flag, upd_index,
        output in_ready, out_valid, out_hit, smallorbig_segment, seg_index, upd_ready, init_done
    );
endinterface
`default_nettype wire

// File: rtl/hashtable_index_lookup_upd.sv
`default_nettype none
// ============================================================================
// Module : hashtable_index_lookup_upd
// Brief  : Hashed segment-table lookup with runtime-updatable, self-clearing table.
// Rev    : 1.0
// ============================================================================
module hashtable_index_lookup_upd #(
    parameter int          INDEX_BIT_LEN   = 11,
    parameter int          PACKET_BIT_LEN  = 104,
    parameter int          SRC_LSB         = 0,
    parameter int          DST_LSB         = 32,
    parameter int          PREFIX_LEN      = 16,
    parameter logic [31:0] MAGIC_NUM       = 32'h80008001,
    parameter int          HASH_SHIFT      = 16,
    parameter int          TABLE_ADDR_BITS = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    hashtable_index_lookup_upd_if.slave bus_io
);
    localparam int KEY_W = 2 * PREFIX_LEN;
    localparam int ENT_W = INDEX_BIT_LEN + 2;
    localparam int DEPTH = 1 << TABLE_ADDR_BITS;
    localparam logic [TABLE_ADDR_BITS-1:0] c_last_addr = '1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     state_q;
    logic [TABLE_ADDR_BITS-1:0] cnt_q;
    logic                       in_ready_q, upd_ready_q, init_done_q;

    logic [KEY_W-1:0]           key_d, key_q;
    logic                       v0_q, v1_q, v2_q;
    logic [31:0]                prod_d;
    logic [TABLE_ADDR_BITS-1:0] addr_d, addr_q;
    logic [ENT_W-1:0]           ent_d, ent_q;

    logic                       out_valid_q, out_hit_q, out_flag_q;
    logic [INDEX_BIT_LEN-1:0]   out_index_q;

    logic                       wr_en_d;
    logic [TABLE_ADDR_BITS-1:0] wr_addr_d;
    logic [ENT_W-1:0]           wr_data_d;

    logic [ENT_W-1:0]           mem_q [DEPTH];

    // Tuple bits outside the two prefixes never reach the hash.
    logic                       unused_tuple;
    assign unused_tuple = ^bus_io.tupleData;

    assign key_d  = {bus_io.tupleData[SRC_LSB +: PREFIX_LEN],
                     bus_io.tupleData[DST_LSB +: PREFIX_LEN]};
    assign prod_d = 32'(key_q) * MAGIC_NUM;
    assign addr_d = TABLE_ADDR_BITS'(prod_d >> HASH_SHIFT);

    // INIT owns the write port; updates only get through once running.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = bus_io.upd_addr;
        wr_data_d = '0;
        if (state_q == ST_INIT) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
        end else begin
            wr_en_d   = bus_io.upd_valid & upd_ready_q;
            wr_data_d = bus_io.upd_clear ? '0
                                         : {1'b1, bus_io.upd_flag, bus_io.upd_index};
        end
    end

    // Write-first: a same-cycle write to the address being read is forwarded.
    assign ent_d = (wr_en_d && (wr_addr_d == addr_q)) ? wr_data_d : mem_q[addr_q];

    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_q[wr_addr_d] <= wr_data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            upd_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            key_q       <= '0;
            v0_q        <= 1'b0;
            addr_q      <= '0;
            v1_q        <= 1'b0;
            ent_q       <= '0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_flag_q  <= 1'b0;
            out_index_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == c_last_addr) begin
                        state_q     <= ST_RUN;
                        in_ready_q  <= 1'b1;
                        upd_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: state_q <= ST_INIT;
            endcase

            key_q       <= key_d;
            v0_q        <= bus_io.in_valid & in_ready_q;
            addr_q      <= addr_d;
            v1_q        <= v0_q;
            ent_q       <= ent_d;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v2_q) begin
                out_hit_q   <= ent_q[ENT_W-1];
                out_flag_q  <= ent_q[ENT_W-2];
                out_index_q <= ent_q[INDEX_BIT_LEN-1:0];
            end
        end
    end

    assign bus_io.in_ready           = in_ready_q;
    assign bus_io.upd_ready          = upd_ready_q;
    assign bus_io.init_done          = init_done_q;
    assign bus_io.out_valid          = out_valid_q;
    assign bus_io.out_hit            = out_hit_q;
    assign bus_io.smallorbig_segment = out_flag_q;
    assign bus_io.seg_index          = out_index_q;
endmodule
`default_nettype wire

// File: tb/tb_hashtable_index_lookup_upd.sv
`default_nettype none
// ============================================================================
// Module : tb_hashtable_index_lookup_upd
// Brief  : Directed scoreboard bench for the hashed segment-table lookup.
// Rev    : 1.0
// ============================================================================
module tb_hashtable_index_lookup_upd;
    localparam int AB = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   next_id = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hashtable_index_lookup_upd_if #(
        .INDEX_BIT_LEN(11), .PACKET_BIT_LEN(104), .TABLE_ADDR_BITS(AB)
    ) hif ();

    hashtable_index_lookup_upd #(
        .INDEX_BIT_LEN(11), .PACKET_BIT_LEN(104), .SRC_LSB(0), .DST_LSB(32),
        .PREFIX_LEN(16), .MAGIC_NUM(32'h80008001), .HASH_SHIFT(16),
        .TABLE_ADDR_BITS(AB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (hif.slave)
    );

    typedef struct {
        int          due;
        logic        hit;
        logic        flag;
        logic [10:0] idx;
        int          id;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst && hif.out_valid) begin
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, required no result", cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (cyc != mon_e.due || hif.out_hit !== mon_e.hit ||
                    hif.smallorbig_segment !== mon_e.flag || hif.seg_index !== mon_e.idx) begin
                    n_fail++;
                    $display("FAIL lookup#%0d: got cyc=%0d hit=%b flag=%b idx=%h, required cyc=%0d hit=%b flag=%b idx=%h",
                             mon_e.id, cyc, hif.out_hit, hif.smallorbig_segment, hif.seg_index,
                             mon_e.due, mon_e.hit, mon_e.flag, mon_e.idx);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [103:0] tup(input logic [15:0] src, input logic [15:0] dst);
        logic [103:0] t;
        t = {13{8'hA5}};
        t[15:0]  = src;
        t[47:32] = dst;
        return t;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lookup(input logic [15:0] src, input logic [15:0] dst, input logic hit,
                          input logic flag, input logic [10:0] idx, input bit push);
        exp_t e;
        hif.in_valid  = 1'b1;
        hif.tupleData = tup(src, dst);
        if (push) begin
            e.due = cyc + 4;
            e.hit = hit;
            e.flag = flag;
            e.idx = idx;
            e.id = next_id;
            next_id++;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        hif.in_valid = 1'b0;
    endtask

    task automatic upd(input logic [AB-1:0] addr, input logic clr, input logic flag,
                       input logic [10:0] idx);
        hif.upd_valid = 1'b1;
        hif.upd_addr  = addr;
        hif.upd_clear = clr;
        hif.upd_flag  = flag;
        hif.upd_index = idx;
        @(posedge clk);
        #1;
        hif.upd_valid = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int  n;
        bit  quiet;
        n = 0;
        quiet = 1'b1;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (hif.init_done) break;
            if (hif.in_ready || hif.upd_ready || hif.out_valid || hif.out_hit ||
                hif.smallorbig_segment || hif.seg_index != 11'h0)
                quiet = 1'b0;
        end
        check({name, "_cycles"}, n, 64);
        check({name, "_quiet"}, {31'h0, quiet}, 1);
        check({name, "_ready"}, {30'h0, hif.in_ready, hif.upd_ready}, 3);
    endtask

    initial begin
        hif.in_valid  = 1'b0;
        hif.tupleData = '0;
        hif.upd_valid = 1'b0;
        hif.upd_addr  = '0;
        hif.upd_clear = 1'b0;
        hif.upd_flag  = 1'b0;
        hif.upd_index = '0;

        idle(2);
        check("reset_outputs",
              {18'h0, hif.out_valid, hif.out_hit, hif.smallorbig_segment, hif.seg_index,
               hif.in_ready, hif.upd_ready, hif.init_done}, 0);
        rst = 1'b0;
        wait_init("init");

        lookup(16'h0001, 16'h0000, 1'b0, 1'b0, 11'h000, 1'b1);
        idle(4);

        upd(6'h01, 1'b0, 1'b1, 11'h2A5);
        lookup(16'h0001, 16'h0000, 1'b1, 1'b1, 11'h2A5, 1'b1);
        idle(4);

        // Write lands on the same edge as the S2 read of addr 0x00.
        lookup(16'h0000, 16'h0001, 1'b1, 1'b0, 11'h123, 1'b1);
        idle(1);
        upd(6'h00, 1'b0, 1'b0, 11'h123);
        idle(4);

        // Write lands one edge after the S2 read: old entry expected.
        lookup(16'h0000, 16'h0001, 1'b1, 1'b0, 11'h123, 1'b1);
        idle(2);
        upd(6'h00, 1'b0, 1'b1, 11'h055);
        idle(4);
        lookup(16'h0000, 16'h0001, 1'b1, 1'b1, 11'h055, 1'b1);
        idle(4);

        lookup(16'h0001, 16'h0000, 1'b1, 1'b1, 11'h2A5, 1'b1);
        lookup(16'h0000, 16'h0001, 1'b1, 1'b1, 11'h055, 1'b1);
        lookup(16'h0000, 16'h0040, 1'b0, 1'b0, 11'h000, 1'b1);
        lookup(16'h0001, 16'h0000, 1'b1, 1'b1, 11'h2A5, 1'b1);
        lookup(16'h0000, 16'h0001, 1'b1, 1'b1, 11'h055, 1'b1);
        idle(5);

        upd(6'h20, 1'b0, 1'b0, 11'h111);
        upd(6'h20, 1'b0, 1'b1, 11'h222);
        lookup(16'h0000, 16'h0040, 1'b1, 1'b1, 11'h222, 1'b1);
        idle(4);

        upd(6'h01, 1'b1, 1'b0, 11'h000);
        lookup(16'h0001, 16'h0000, 1'b0, 1'b0, 11'h000, 1'b1);
        idle(4);

        // Reset with two lookups in flight: neither may produce a result.
        upd(6'h01, 1'b0, 1'b1, 11'h3FF);
        idle(1);
        lookup(16'h0001, 16'h0000, 1'b0, 1'b0, 11'h000, 1'b0);
        lookup(16'h0001, 16'h0000, 1'b0, 1'b0, 11'h000, 1'b0);
        rst = 1'b1;
        idle(2);
        check("midrst_outputs",
              {18'h0, hif.out_valid, hif.out_hit, hif.smallorbig_segment, hif.seg_index,
               hif.in_ready, hif.upd_ready, hif.init_done}, 0);
        rst = 1'b0;
        wait_init("reinit");
        lookup(16'h0001, 16'h0000, 1'b0, 1'b0, 11'h000, 1'b1);
        idle(6);

        check("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
